prsc_column_requant_stream: RTL and testbench

- Sits directly downstream of the core overlap-add stage. Consumes the overlapped columns that stage produces: one column per valid cycle, with 2*PIX_WIDTH signed partial sums per pixel.
- Requantizes each pixel to PIX_WIDTH (rounding shift, saturate, optional ReLU) and tags the last column of each tile.
- Buffers columns in a small FIFO and presents them on a ready/valid stream towards the output writer.
- The upstream stage has no backpressure, so FIFO overflow is detected and flagged, never stalled.

---
 rtl/prsc_column_requant_stream_pkg.sv | 44 ++++
 rtl/prsc_column_requant_stream_fifo.sv | 61 ++++++
 rtl/prsc_column_requant_stream.sv | 100 ++++++++++
 tb/tb_prsc_column_requant_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/prsc_column_requant_stream_pkg.sv
// Shared sizing and requantization helpers for the overlap-add output path.
// Column geometry is derived from the core/kernel/stride setup so it tracks the overlap stage.
package prsc_column_requant_stream_pkg;

    localparam int PIX_WIDTH    = 8;
    localparam int CORE_IN_SIZE = 2;
    localparam int KERNEL_SIZE  = 4;
    localparam int STRIDE       = 2;

    typedef logic signed [2*PIX_WIDTH-1:0] acc_pix_t;
    typedef logic        [PIX_WIDTH-1:0]   pix_t;
    typedef logic signed [2*PIX_WIDTH:0]   ext_pix_t;

    function automatic int size_of_prsc_input(input int core_in, input int kernel);
        return core_in * kernel;
    endfunction

    function automatic int size_of_prsc_output(input int core_in, input int kernel, input int stride);
        return (core_in - 1) * stride + kernel;
    endfunction

    localparam int SIZE_OF_PRSC_INPUT  = size_of_prsc_input(CORE_IN_SIZE, KERNEL_SIZE);
    localparam int SIZE_OF_PRSC_OUTPUT = size_of_prsc_output(CORE_IN_SIZE, KERNEL_SIZE, STRIDE);

    localparam ext_pix_t SAT_MAX = {{(PIX_WIDTH+2){1'b0}}, {(PIX_WIDTH-1){1'b1}}};
    localparam ext_pix_t SAT_MIN = {{(PIX_WIDTH+2){1'b1}}, {(PIX_WIDTH-1){1'b0}}};
    localparam ext_pix_t RND_ONE = {{(2*PIX_WIDTH){1'b0}}, 1'b1};

    // One extra bit of headroom keeps the rounding add from wrapping.
    function automatic pix_t sat_round(input acc_pix_t x, input logic [7:0] sh, input logic relu);
        ext_pix_t xe;
        ext_pix_t rnd;
        ext_pix_t y;
        xe  = {x[2*PIX_WIDTH-1], x};
        rnd = '0;
        if (sh != 8'd0) rnd = RND_ONE <<< (sh - 8'd1);
        y = (xe + rnd) >>> sh;
        if (y > SAT_MAX)      y = SAT_MAX;
        else if (y < SAT_MIN) y = SAT_MIN;
        if (relu && y[2*PIX_WIDTH]) y = '0;
        return y[PIX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/prsc_column_requant_stream_fifo.sv
// Generic synchronous FIFO with occupancy; a write into a full FIFO succeeds only alongside a read.
// Head data reads as zero while empty so downstream never sees stale entries.
module col_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [WIDTH-1:0]               wr_data_i,
    input  logic                           rd_en_i,
    output logic [WIDTH-1:0]               rd_data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign do_rd     = rd_en_i & ~empty_o;
    assign do_wr     = wr_en_i & (~full_o | do_rd);
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/prsc_column_requant_stream.sv
// Requantizes overlap-add columns to PIX_WIDTH, tags tile ends and streams them out via a FIFO.
// The upstream cannot stall, so a full FIFO drops columns and raises a sticky overflow flag.
module prsc_column_requant_stream
    import prsc_column_requant_stream_pkg::*;
#(
    parameter int COL_LEN       = SIZE_OF_PRSC_OUTPUT,
    parameter int COLS_PER_TILE = SIZE_OF_PRSC_OUTPUT,
    parameter int FIFO_DEPTH    = 4,
    parameter int SHIFT_W       = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                en_i,
    input  logic                                valid_i,
    input  logic [2*PIX_WIDTH*COL_LEN-1:0]      column_i,
    input  logic [SHIFT_W-1:0]                  shift_i,
    input  logic                                relu_en_i,
    input  logic                                clear_i,
    output logic [PIX_WIDTH*COL_LEN-1:0]        m_data_o,
    output logic                                m_valid_o,
    output logic                                m_last_o,
    input  logic                                m_ready_i,
    output logic                                overflow_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fill_o
);
    localparam int OUT_W = PIX_WIDTH * COL_LEN;
    localparam int CNT_W = (COLS_PER_TILE > 1) ? $clog2(COLS_PER_TILE) : 1;

    logic             accept;
    logic             s1_vld_q, s1_vld_d;
    logic [OUT_W-1:0] s1_data_q, s1_data_d;
    logic             s1_last_q, s1_last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full, empty, push, pop, drop;
    logic [OUT_W:0]   head;

    assign accept = en_i & valid_i;
    assign pop    = m_valid_o & m_ready_i;
    assign push   = s1_vld_q & (~full | pop);
    assign drop   = s1_vld_q & full & ~pop;

    always_comb begin
        s1_vld_d  = accept;
        s1_data_d = s1_data_q;
        s1_last_d = s1_last_q;
        if (accept) begin
            for (int k = 0; k < COL_LEN; k++) begin
                s1_data_d[k*PIX_WIDTH +: PIX_WIDTH] =
                    sat_round(column_i[k*2*PIX_WIDTH +: 2*PIX_WIDTH], 8'(shift_i), relu_en_i);
            end
            s1_last_d = (cnt_q == CNT_W'(COLS_PER_TILE-1));
        end
    end

    // Dropped columns still advance the counter so tile framing stays aligned.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)     cnt_d = '0;
        else if (accept) cnt_d = (cnt_q == CNT_W'(COLS_PER_TILE-1)) ? '0 : cnt_q + 1'b1;
        ovf_d = clear_i ? 1'b0 : (ovf_q | drop);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_last_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s1_last_q <= s1_last_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    col_sync_fifo #(
        .WIDTH (OUT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (push),
        .wr_data_i ({s1_last_q, s1_data_q}),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (fill_o)
    );

    assign m_valid_o  = ~empty;
    assign m_data_o   = head[OUT_W-1:0];
    assign m_last_o   = head[OUT_W];
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_prsc_column_requant_stream.sv
// Randomized and directed checks of the requant stream against a queue-based reference model.
module tb_prsc_column_requant_stream;
    localparam int PW = 8, CL = 6, CPT = 6, DEPTH = 4, SW = 4;
    localparam int IW = 2*PW*CL, OW = PW*CL;

    logic          clk_i = 1'b0;
    logic          rst_i, en_i, valid_i, relu_en_i, clear_i, m_ready_i;
    logic [IW-1:0] column_i;
    logic [SW-1:0] shift_i;
    logic [OW-1:0] m_data_o;
    logic          m_valid_o, m_last_o, overflow_o;
    logic [2:0]    fill_o;

    prsc_column_requant_stream dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .column_i(column_i),
        .shift_i(shift_i), .relu_en_i(relu_en_i), .clear_i(clear_i), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
        .overflow_o(overflow_o), .fill_o(fill_o)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0, nerr = 0;

    typedef struct { logic [OW-1:0] d; logic l; } ent_t;
    ent_t mq[$];
    bit   p_v;
    ent_t p_e;
    int   m_cnt;
    bit   m_ovf;

    function automatic logic [OW-1:0] ref_col(input logic [IW-1:0] c, input int s, input bit relu);
        logic [OW-1:0] r;
        int x, y;
        r = '0;
        for (int k = 0; k < CL; k++) begin
            x = int'($signed(c[k*2*PW +: 2*PW]));
            y = (s == 0) ? x : ((x + (1 << (s-1))) >>> s);
            if (y > 127)  y = 127;
            if (y < -128) y = -128;
            if (relu && y < 0) y = 0;
            r[k*PW +: PW] = y[PW-1:0];
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] rnd_col();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        mq.delete();
        p_v = 0; m_cnt = 0; m_ovf = 0;
    endtask

    // Drives one cycle of inputs, advances the model across the edge, returns at edge+1.
    task automatic step(input bit en, input bit v, input logic [IW-1:0] c, input int s,
                        input bit relu, input bit rdy, input bit clr);
        bit full_b, pop, drop;
        en_i = en; valid_i = v; column_i = c; shift_i = SW'(s);
        relu_en_i = relu; m_ready_i = rdy; clear_i = clr;
        full_b = (mq.size() == DEPTH);
        pop    = (mq.size() > 0) && rdy;
        drop   = 0;
        if (pop) void'(mq.pop_front());
        if (p_v) begin
            if (!full_b || pop) mq.push_back(p_e);
            else drop = 1;
        end
        m_ovf = clr ? 1'b0 : (m_ovf | drop);
        p_v = en && v;
        if (p_v) begin
            p_e.d = ref_col(c, s, relu);
            p_e.l = (m_cnt == CPT-1);
        end
        if (clr) m_cnt = 0;
        else if (en && v) m_cnt = (m_cnt + 1) % CPT;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 0; en_i = 0; valid_i = 0; column_i = '0; shift_i = '0;
        relu_en_i = 0; clear_i = 0; m_ready_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        nvec++; if (m_valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", m_valid_o); end
        nvec++; if (m_last_o !== 1'b0) begin nerr++; $display("FAIL reset_last got %b exp 0", m_last_o); end
        nvec++; if (m_data_o !== '0) begin nerr++; $display("FAIL reset_data got %h exp 0", m_data_o); end
        nvec++; if (overflow_o !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b exp 0", overflow_o); end
        nvec++; if (fill_o !== 3'd0) begin nerr++; $display("FAIL reset_fill got %0d exp 0", fill_o); end
        rst_i = 1;
    endtask

    task automatic test_saturation();
        logic [IW-1:0] c;
        c = 96'h0000_FF80_007F_FF00_0100_0005;
        step(1, 1, c, 0, 0, 0, 0);
        nvec++; if (m_valid_o !== 1'b0) begin nerr++; $display("FAIL sat_lat1 m_valid got %b exp 0", m_valid_o); end
        step(1, 0, '0, 0, 0, 0, 0);
        nvec++; if (m_valid_o !== 1'b1) begin nerr++; $display("FAIL sat_lat2 m_valid got %b exp 1", m_valid_o); end
        nvec++; if (m_data_o !== 48'h00807F807F05) begin nerr++; $display("FAIL sat_data got %h exp 00807f807f05", m_data_o); end
        nvec++; if (m_data_o !== mq[0].d) begin nerr++; $display("FAIL sat_model got %h exp %h", m_data_o, mq[0].d); end
        step(1, 0, '0, 0, 0, 1, 0);
        nvec++; if (m_valid_o !== 1'b0 || fill_o !== 3'd0) begin nerr++; $display("FAIL sat_drain valid %b fill %0d exp 0 0", m_valid_o, fill_o); end
    endtask

    task automatic test_round_relu();
        logic [IW-1:0] c;
        c = {64'h0, 16'hFFF6, 16'h000A};
        step(1, 1, c, 2, 0, 0, 0);
        step(1, 1, c, 2, 1, 0, 0);
        nvec++; if (m_data_o !== 48'h0000_0000_FE03) begin nerr++; $display("FAIL round_data got %h exp fe03", m_data_o); end
        step(1, 0, '0, 2, 0, 1, 0);
        nvec++; if (m_data_o !== 48'h0000_0000_0003) begin nerr++; $display("FAIL relu_data got %h exp 0003", m_data_o); end
        nvec++; if (m_data_o !== mq[0].d) begin nerr++; $display("FAIL relu_model got %h exp %h", m_data_o, mq[0].d); end
        step(1, 0, '0, 2, 0, 1, 0);
        nvec++; if (m_valid_o !== 1'b0) begin nerr++; $display("FAIL relu_drain m_valid got %b exp 0", m_valid_o); end
    endtask

    task automatic test_tile_framing();
        int beats;
        beats = 0;
        step(1, 0, '0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, i < 7, rnd_col(), 3, 0, 1, 0);
            if (m_valid_o) begin
                beats++;
                nvec++; if (m_last_o !== (beats == 6)) begin nerr++; $display("FAIL tile_last beat %0d got %b exp %b", beats, m_last_o, beats == 6); end
                nvec++; if (mq.size() == 0 || m_data_o !== mq[0].d) begin nerr++; $display("FAIL tile_data beat %0d got %h", beats, m_data_o); end
            end
        end
        nvec++; if (beats != 7) begin nerr++; $display("FAIL tile_beats got %0d exp 7", beats); end
    endtask

    task automatic test_overflow();
        logic [IW-1:0] cols [5];
        step(1, 0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cols[i] = rnd_col();
            step(1, 1, cols[i], 1, 0, 0, 0);
        end
        step(1, 0, '0, 1, 0, 0, 0);
        nvec++; if (overflow_o !== 1'b1) begin nerr++; $display("FAIL ovf_flag got %b exp 1", overflow_o); end
        step(1, 0, '0, 1, 0, 0, 0);
        nvec++; if (fill_o !== 3'd4) begin nerr++; $display("FAIL ovf_fill got %0d exp 4", fill_o); end
        for (int i = 0; i < 4; i++) begin
            nvec++; if (m_data_o !== ref_col(cols[i], 1, 0)) begin nerr++; $display("FAIL ovf_order col %0d got %h exp %h", i, m_data_o, ref_col(cols[i], 1, 0)); end
            step(1, 0, '0, 1, 0, 1, 0);
        end
        nvec++; if (m_valid_o !== 1'b0) begin nerr++; $display("FAIL ovf_drained m_valid got %b exp 0", m_valid_o); end
        step(1, 1, rnd_col(), 1, 0, 0, 0);
        step(1, 1, rnd_col(), 1, 0, 0, 0);
        step(1, 0, '0, 1, 0, 0, 0);
        nvec++; if (m_last_o !== 1'b1) begin nerr++; $display("FAIL ovf_align1 m_last got %b exp 1", m_last_o); end
        step(1, 0, '0, 1, 0, 1, 0);
        nvec++; if (m_valid_o !== 1'b1 || m_last_o !== 1'b0) begin nerr++; $display("FAIL ovf_align2 valid %b last %b exp 1 0", m_valid_o, m_last_o); end
        nvec++; if (overflow_o !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b exp 1", overflow_o); end
        step(1, 0, '0, 1, 0, 1, 0);
    endtask

    task automatic test_full_pop();
        step(1, 0, '0, 0, 0, 0, 1);
        nvec++; if (overflow_o !== 1'b0) begin nerr++; $display("FAIL fp_clear ovf got %b exp 0", overflow_o); end
        for (int i = 0; i < 4; i++) step(1, 1, rnd_col(), 0, 1, 0, 0);
        step(1, 0, '0, 0, 0, 0, 0);
        step(1, 1, rnd_col(), 0, 0, 0, 0);
        nvec++; if (fill_o !== 3'd4) begin nerr++; $display("FAIL fp_full got %0d exp 4", fill_o); end
        step(1, 0, '0, 0, 0, 1, 0);
        nvec++; if (fill_o !== 3'd4) begin nerr++; $display("FAIL fp_fill got %0d exp 4", fill_o); end
        nvec++; if (overflow_o !== 1'b0) begin nerr++; $display("FAIL fp_ovf got %b exp 0", overflow_o); end
        for (int i = 0; i < 5; i++) begin
            nvec++; if (m_data_o !== mq[0].d) begin nerr++; $display("FAIL fp_drain %0d got %h exp %h", i, m_data_o, mq[0].d); end
            step(1, 0, '0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_reset_midtile();
        int beats;
        beats = 0;
        step(1, 0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, rnd_col(), 0, 0, 0, 0);
        #1 rst_i = 0;
        model_reset();
        #1;
        nvec++; if (m_valid_o !== 1'b0 || m_last_o !== 1'b0 || m_data_o !== '0 || fill_o !== 3'd0 || overflow_o !== 1'b0)
            begin nerr++; $display("FAIL midreset valid %b last %b data %h fill %0d ovf %b exp all 0", m_valid_o, m_last_o, m_data_o, fill_o, overflow_o); end
        valid_i = 0;
        @(posedge clk_i); #1;
        rst_i = 1;
        for (int i = 0; i < 9; i++) begin
            step(1, i < 6, rnd_col(), 0, 0, 1, 0);
            if (m_valid_o) begin
                beats++;
                nvec++; if (m_last_o !== (beats == 6)) begin nerr++; $display("FAIL midreset_last beat %0d got %b exp %b", beats, m_last_o, beats == 6); end
            end
        end
        nvec++; if (beats != 6) begin nerr++; $display("FAIL midreset_beats got %0d exp 6", beats); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom % 2, rnd_col(), $urandom % 16, $urandom % 2,
                 ($urandom % 3) != 0, ($urandom % 50) == 0);
            nvec++; if (m_valid_o !== (mq.size() > 0)) begin nerr++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, m_valid_o, mq.size() > 0); end
            nvec++; if (fill_o !== 3'(mq.size())) begin nerr++; $display("FAIL rnd_fill cyc %0d got %0d exp %0d", i, fill_o, mq.size()); end
            nvec++; if (overflow_o !== m_ovf) begin nerr++; $display("FAIL rnd_ovf cyc %0d got %b exp %b", i, overflow_o, m_ovf); end
            if (mq.size() > 0) begin
                nvec++; if (m_data_o !== mq[0].d || m_last_o !== mq[0].l)
                    begin nerr++; $display("FAIL rnd_head cyc %0d got %h/%b exp %h/%b", i, m_data_o, m_last_o, mq[0].d, mq[0].l); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_saturation();
        test_round_relu();
        test_tile_framing();
        test_overflow();
        test_full_pop();
        test_reset_midtile();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
